// File: rtl/systolic_pkg.sv
// Shared types and sizing for the systolic operand feeder (optional build macro: SYSTOLIC_FEEDER_TRANSPOSE_B_EN).
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package systolic_pkg;

   localparam int DEF_MATRIX_SIZE = 3;
   localparam int DEF_DATA_SIZE   = 8;
   localparam int FEED_STEPS      = 3*DEF_MATRIX_SIZE - 2;
   localparam int DRAIN_STEPS     = DEF_MATRIX_SIZE;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      FEED,
      DRAIN,
      DONE
   } feeder_state_t;

   // Step counts for an arbitrary array size, so a resized top stays consistent.
   function automatic int feed_steps(input int n);
      return 3*n - 2;
   endfunction

   function automatic int drain_steps(input int n);
      return n;
   endfunction

endpackage

// File: rtl/systolic_feeder_if.sv
// Bundle between operand controller (master) and systolic feeder (slave).
// Latency: none, wiring only.
// Backpressure: none; start is a request sampled only when the feeder is idle.
interface systolic_feeder_if #(
   parameter int N  = systolic_pkg::DEF_MATRIX_SIZE,
   parameter int DW = systolic_pkg::DEF_DATA_SIZE
);
   logic          start;
   logic [DW-1:0] mat_a [N*N];
   logic [DW-1:0] mat_b [N*N];
   logic          busy;
   logic          array_clear;
   logic [DW-1:0] feed_a [N];
   logic [DW-1:0] feed_b [N];
   logic          feed_valid;
   logic          done;

   modport master (
      output start, mat_a, mat_b,
      input  busy, array_clear, feed_a, feed_b, feed_valid, done
   );

   modport slave (
      input  start, mat_a, mat_b,
      output busy, array_clear, feed_a, feed_b, feed_valid, done
   );
endinterface

// File: rtl/systolic_skew_sel.sv
// Per-lane skew selector: picks operand k of lane LANE when step == LANE + k, else zero.
// Latency: combinational.
// Backpressure: none.
module systolic_skew_sel #(
   parameter int N    = 3,
   parameter int DW   = 8,
   parameter int LANE = 0,
   parameter int CW   = 4
) (
   input  logic [CW-1:0] i_step,
   input  logic [DW-1:0] i_ops [N],
   output logic [DW-1:0] o_dat
);

   // Lane LANE sees its operands delayed by LANE steps; outside that window it is zero-padded.
   always_comb begin
      o_dat = '0;
      for (int k = 0; k < N; k++) begin
         if (i_step == CW'(LANE + k)) begin
            o_dat = i_ops[k];
         end
      end
   end

endmodule

// File: rtl/systolic_feeder.sv
// Latches A/B on start and feeds skewed, zero-padded operand streams into an NxN systolic array (macro SYSTOLIC_FEEDER_TRANSPOSE_B_EN: mat_b is column-major).
// Latency: clear in cycle 1, feed cycles 2..3N-1, drain 3N..4N-1, done in cycle 4N after start.
// Backpressure: none; start is ignored while busy, next start accepted from cycle 4N+1.
module systolic_feeder
   import systolic_pkg::*;
#(
   parameter int MATRIX_SIZE = DEF_MATRIX_SIZE,
   parameter int DATA_SIZE   = DEF_DATA_SIZE
) (
   input  logic             clk,
   input  logic             reset,
   systolic_feeder_if.slave bus
);

   localparam int N  = MATRIX_SIZE;
   localparam int CW = $clog2(3*N);
   localparam logic [CW-1:0] FEED_LAST  = CW'(feed_steps(N) - 1);
   localparam logic [CW-1:0] DRAIN_LAST = CW'(drain_steps(N) - 1);

   feeder_state_t        r_state;
   feeder_state_t        w_state_nxt;
   logic [CW-1:0]        r_cnt;
   logic [CW-1:0]        w_cnt_nxt;

   logic [DATA_SIZE-1:0] r_mat_a [N*N];
   logic [DATA_SIZE-1:0] r_mat_b [N*N];
   logic [DATA_SIZE-1:0] w_a_lane [N][N];
   logic [DATA_SIZE-1:0] w_b_lane [N][N];
   logic [DATA_SIZE-1:0] w_sel_a [N];
   logic [DATA_SIZE-1:0] w_sel_b [N];

   logic                 r_busy;
   logic                 r_clear;
   logic                 r_feed_valid;
   logic                 r_done;
   logic [DATA_SIZE-1:0] r_feed_a [N];
   logic [DATA_SIZE-1:0] r_feed_b [N];

   // Regroup the captured matrices into lanes: A lane r carries A[r][k], B lane c carries B[k][c].
   for (genvar r = 0; r < N; r++) begin : g_lane
      for (genvar k = 0; k < N; k++) begin : g_op
         assign w_a_lane[r][k] = r_mat_a[r*N + k];
`ifdef SYSTOLIC_FEEDER_TRANSPOSE_B_EN
         assign w_b_lane[r][k] = r_mat_b[r*N + k];
`else
         assign w_b_lane[r][k] = r_mat_b[k*N + r];
`endif
      end

      // Selectors look at the upcoming step so the feed registers hold step t during FEED step t.
      systolic_skew_sel #(.N(N), .DW(DATA_SIZE), .LANE(r), .CW(CW)) u_sel_a (
         .i_step (w_cnt_nxt),
         .i_ops  (w_a_lane[r]),
         .o_dat  (w_sel_a[r])
      );

      systolic_skew_sel #(.N(N), .DW(DATA_SIZE), .LANE(r), .CW(CW)) u_sel_b (
         .i_step (w_cnt_nxt),
         .i_ops  (w_b_lane[r]),
         .o_dat  (w_sel_b[r])
      );

      assign bus.feed_a[r] = r_feed_a[r];
      assign bus.feed_b[r] = r_feed_b[r];
   end

   // Next state and step counter; the counter restarts at 0 on every state entry.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = '0;
      case (r_state)
         IDLE:  if (bus.start) w_state_nxt = CLEAR;
         CLEAR: w_state_nxt = FEED;
         FEED: begin
            if (r_cnt == FEED_LAST) w_state_nxt = DRAIN;
            else                    w_cnt_nxt   = r_cnt + 1'b1;
         end
         DRAIN: begin
            if (r_cnt == DRAIN_LAST) w_state_nxt = DONE;
            else                     w_cnt_nxt   = r_cnt + 1'b1;
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // State register plus outputs registered from the upcoming state, so they align with it.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_cnt        <= '0;
         r_busy       <= 1'b0;
         r_clear      <= 1'b0;
         r_feed_valid <= 1'b0;
         r_done       <= 1'b0;
         for (int r = 0; r < N; r++) begin
            r_feed_a[r] <= '0;
            r_feed_b[r] <= '0;
         end
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_busy       <= (w_state_nxt != IDLE);
         r_clear      <= (w_state_nxt == CLEAR);
         r_feed_valid <= (w_state_nxt == FEED);
         r_done       <= (w_state_nxt == DONE);
         for (int r = 0; r < N; r++) begin
            r_feed_a[r] <= (w_state_nxt == FEED) ? w_sel_a[r] : '0;
            r_feed_b[r] <= (w_state_nxt == FEED) ? w_sel_b[r] : '0;
         end
      end
   end

   // Operand capture happens only on an accepted start; reset discards any held matrices.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N*N; i++) begin
            r_mat_a[i] <= '0;
            r_mat_b[i] <= '0;
         end
      end else if (r_state == IDLE && bus.start) begin
         for (int i = 0; i < N*N; i++) begin
            r_mat_a[i] <= bus.mat_a[i];
            r_mat_b[i] <= bus.mat_b[i];
         end
      end
   end

   assign bus.busy        = r_busy;
   assign bus.array_clear = r_clear;
   assign bus.feed_valid  = r_feed_valid;
   assign bus.done        = r_done;

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: cycle-indexed reference model, downstream array model, directed scenarios.
// Latency: checks every cycle at the falling edge.
// Backpressure: none; start pulses are applied while busy to confirm they are ignored.
module tb_systolic_feeder;

   localparam int N  = 3;
   localparam int DW = 8;

   logic clk = 1'b0;
   logic reset;
   bit   chk_en = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;
   int   done_cnt = 0;

   always #5 clk = ~clk;

   systolic_feeder_if #(.N(N), .DW(DW)) bus();

   systolic_feeder #(.MATRIX_SIZE(N), .DATA_SIZE(DW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Logical B[k][c] position inside mat_b for the active layout.
   function automatic int idx_b(input int k, input int c);
`ifdef SYSTOLIC_FEEDER_TRANSPOSE_B_EN
      return c*N + k;
`else
      return k*N + c;
`endif
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: m_cyc is the cycle index since the accepted start (0 = idle).
   int m_cyc = 0;
   int m_a [N][N];
   int m_b [N][N];

   always @(posedge clk) begin
      if (reset) begin
         m_cyc <= 0;
      end else if (m_cyc == 0) begin
         if (bus.start === 1'b1) begin
            m_cyc <= 1;
            for (int k = 0; k < N; k++)
               for (int c = 0; c < N; c++) begin
                  m_a[k][c] <= int'(bus.mat_a[k*N + c]);
                  m_b[k][c] <= int'(bus.mat_b[idx_b(k, c)]);
               end
         end
      end else if (m_cyc == 4*N) begin
         m_cyc <= 0;
      end else begin
         m_cyc <= m_cyc + 1;
      end
   end

   function automatic logic [63:0] exp_vec(input int n);
      logic [63:0] v;
      int t;
      logic fv;
      fv = (n >= 2) && (n <= 3*N - 1);
      t  = n - 2;
      v  = {60'd0, (n >= 1), (n == 1), fv, (n == 4*N)};
      for (int r = 0; r < N; r++)
         v = (v << DW) | ((fv && t >= r && t < r + N) ? 64'(m_a[r][t-r]) : 64'd0);
      for (int c = 0; c < N; c++)
         v = (v << DW) | ((fv && t >= c && t < c + N) ? 64'(m_b[t-c][c]) : 64'd0);
      return v;
   endfunction

   function automatic logic [63:0] pack_a();
      logic [63:0] v = '0;
      for (int r = 0; r < N; r++) v = (v << DW) | 64'(bus.feed_a[r]);
      return v;
   endfunction

   function automatic logic [63:0] pack_b();
      logic [63:0] v = '0;
      for (int c = 0; c < N; c++) v = (v << DW) | 64'(bus.feed_b[c]);
      return v;
   endfunction

   function automatic logic [63:0] act_vec();
      logic [63:0] v;
      v = {60'd0, bus.busy, bus.array_clear, bus.feed_valid, bus.done};
      for (int r = 0; r < N; r++) v = (v << DW) | 64'(bus.feed_a[r]);
      for (int c = 0; c < N; c++) v = (v << DW) | 64'(bus.feed_b[c]);
      return v;
   endfunction

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (chk_en) check($sformatf("model_cyc%0d", m_cyc), act_vec(), exp_vec(m_cyc));
      if (bus.done === 1'b1) done_cnt++;
   end

   // Output-stationary array consumer: a moves right, b moves down, 8-bit accumulators.
   logic [DW-1:0] pa  [N][N];
   logic [DW-1:0] pb  [N][N];
   logic [DW-1:0] acc [N][N];

   always @(posedge clk) begin
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            logic [DW-1:0] ain, bin;
            if (j == 0) ain = bus.feed_a[i];
            else        ain = pa[i][j-1];
            if (i == 0) bin = bus.feed_b[j];
            else        bin = pb[i-1][j];
            pa[i][j]  <= ain;
            pb[i][j]  <= bin;
            acc[i][j] <= bus.array_clear ? '0 : DW'(acc[i][j] + ain * bin);
         end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // mode 0: A=1..9, B=identity; mode 1: A=1..9, B=9..1; mode 2: all 0xFF.
   task automatic set_ab(input int mode);
      for (int k = 0; k < N; k++)
         for (int c = 0; c < N; c++) begin
            int bv;
            case (mode)
               0:       bv = (k == c) ? 1 : 0;
               1:       bv = 9 - (k*N + c);
               default: bv = 255;
            endcase
            bus.mat_a[k*N + c]     = (mode == 2) ? 8'hFF : DW'(k*N + c + 1);
            bus.mat_b[idx_b(k, c)] = DW'(bv);
         end
   endtask

   int e2e [N*N] = '{30, 24, 18, 84, 69, 54, 138, 114, 90};

   initial begin
      reset     = 1'b1;
      bus.start = 1'b1;
      set_ab(0);

      // Reset held with start high: everything stays quiet.
      tick();
      chk_en = 1'b1;
      check("reset_hold", act_vec(), 64'd0);
      repeat (3) begin
         tick();
         check("reset_hold", act_vec(), 64'd0);
      end
      reset     = 1'b0;
      bus.start = 1'b0;
      tick();

      // Skew pattern: A = 1..9, B = identity.
      set_ab(0);
      bus.start = 1'b1;                       // cycle 0
      tick();
      bus.start = 1'b0;                       // cycle 1
      check("clear_c1", 64'(bus.array_clear), 64'd1);
      tick();                                 // cycle 2, step 0
      check("step0_a", pack_a(), 64'h010000);
      check("step0_b", pack_b(), 64'h010000);
      check("step0_valid", 64'(bus.feed_valid), 64'd1);
      tick(); tick();                         // step 2
      check("step2_a", pack_a(), 64'h030507);
      check("step2_b", pack_b(), 64'h000100);
      tick(); tick();                         // step 4
      check("step4_a", pack_a(), 64'h000009);
      check("step4_b", pack_b(), 64'h000001);
      repeat (5) tick();                      // cycle 11
      check("no_done_c11", 64'(bus.done), 64'd0);
      tick();                                 // cycle 12
      check("done_c12", 64'(bus.done), 64'd1);
      tick();                                 // cycle 13
      check("idle_c13", 64'(bus.busy), 64'd0);

      // End-to-end with a start pulse mid-FEED that must be ignored.
      done_cnt = 0;
      set_ab(1);
      bus.start = 1'b1;                       // cycle 0
      tick();
      bus.start = 1'b0;
      repeat (4) tick();                      // cycle 5
      set_ab(2);
      bus.start = 1'b1;
      tick();                                 // cycle 6
      bus.start = 1'b0;
      repeat (6) tick();                      // cycle 12
      check("e2e_done_c12", 64'(bus.done), 64'd1);
      for (int i = 0; i < N*N; i++)
         check($sformatf("e2e_c%0d", i), 64'(acc[i/N][i%N]), 64'(e2e[i]));
      tick();                                 // cycle 13
      check("single_done", 64'(done_cnt), 64'd1);

      // Start at cycle 13 is accepted; then reset in its cycle 6.
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check("restart_clear", 64'(bus.array_clear), 64'd1);
      repeat (5) tick();                      // cycle 6 of this run
      reset = 1'b1;
      tick();                                 // cycle 7
      reset = 1'b0;
      check("rst_mid_outputs", act_vec(), 64'd0);
      done_cnt = 0;
      repeat (40) tick();
      check("no_done_after_rst", 64'(done_cnt), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
